// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: message buffer presenting a static or left-scrolling 8-digit window to display_alphahex
//
// Ports:
//   clk_in, rst_in  clock and synchronous active-high reset
//   load            one-cycle strobe capturing msg_in / msg_len
//   msg_in          MSG_MAX 6-bit letter codes, index 0 leftmost
//   msg_len         message length, clamped to MSG_MAX
//   enable          1 = display active, 0 = blank output and frozen state
//   data_out        8 digit codes, [7] leftmost, 0 = blank
//   scrolling       loaded length exceeds 8
//   wrapped         one-cycle pulse when the scroll window returns to position 0
//
// Build option: define SCROLLER_BLINK_EN to blink static messages with a STEP_CYCLES phase.
module seg_msg_scroller #(
    parameter int MSG_MAX     = 16,
    parameter int GAP         = 4,
    parameter int STEP_CYCLES = 16_250_000
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             load,
    input  logic [MSG_MAX-1:0][5:0]          msg_in,
    input  logic [$clog2(MSG_MAX+1)-1:0]     msg_len,
    input  logic                             enable,
    output logic [7:0][5:0]                  data_out,
    output logic                             scrolling,
    output logic                             wrapped
);
    localparam int LW = $clog2(MSG_MAX + 1);
    localparam int IW = $clog2(2 * (MSG_MAX + GAP));
    localparam int BW = $clog2(MSG_MAX);
    localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STATIC = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    logic [MSG_MAX-1:0][5:0] buf_q, buf_d;
    logic [LW-1:0]           len_q, len_d, len_clamp;
    logic [1:0]              st_q, st_d;
    logic [IW-1:0]           pos_q, pos_d, period, idx;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    wrap_q, wrap_d, tc, run, last, blank;
    logic [7:0][5:0]         win, dout_q, dout_d;
    logic                    scrolling_q, wrapped_q;

    assign len_clamp = msg_len > LW'(MSG_MAX) ? LW'(MSG_MAX) : msg_len;
    assign period    = IW'(len_q) + IW'(GAP);
    assign tc        = cnt_q == CW'(STEP_CYCLES - 1);
    assign last      = pos_q == period - IW'(1);

`ifdef SCROLLER_BLINK_EN
    logic phase_q, phase_d;
    assign run   = enable && (st_q == ST_SCROLL || st_q == ST_STATIC);
    assign blank = phase_q && st_q == ST_STATIC;
`else
    assign run   = enable && st_q == ST_SCROLL;
    assign blank = 1'b0;
`endif

    // Window: pos+k never reaches 2P, so one conditional subtraction is a full modulo.
    // Static mode keeps pos at 0 and skips the wrap so blanks follow a short message.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = 0; k < 8; k++) begin
            idx = pos_q + IW'(k);
            if (st_q == ST_SCROLL && idx >= period) idx = idx - period;
            win[7-k] = idx < IW'(len_q) ? buf_q[BW'(idx)] : 6'd0;
        end
    end

    // A load takes priority over a step landing on the same edge.
    always_comb begin
        buf_d  = buf_q;
        len_d  = len_q;
        st_d   = st_q;
        pos_d  = pos_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
`ifdef SCROLLER_BLINK_EN
        phase_d = phase_q;
`endif
        if (load) begin
            buf_d = msg_in;
            len_d = len_clamp;
            st_d  = len_clamp == '0 ? ST_IDLE : len_clamp > LW'(8) ? ST_SCROLL : ST_STATIC;
            pos_d = '0;
            cnt_d = '0;
`ifdef SCROLLER_BLINK_EN
            phase_d = 1'b0;
`endif
        end else if (run) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
            if (tc && st_q == ST_SCROLL) begin
                pos_d  = last ? '0 : pos_q + 1'b1;
                wrap_d = last;
            end
`ifdef SCROLLER_BLINK_EN
            if (tc && st_q == ST_STATIC) phase_d = ~phase_q;
`endif
        end
    end

    assign dout_d = enable && !blank ? win : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            buf_q       <= '0;
            len_q       <= '0;
            st_q        <= ST_IDLE;
            pos_q       <= '0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            dout_q      <= '0;
            scrolling_q <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            len_q       <= len_d;
            st_q        <= st_d;
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            dout_q      <= dout_d;
            scrolling_q <= st_q == ST_SCROLL;
            wrapped_q   <= wrap_q;
        end
    end

`ifdef SCROLLER_BLINK_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) phase_q <= 1'b0;
        else phase_q <= phase_d;
    end
`endif

    assign data_out  = dout_q;
    assign scrolling = scrolling_q;
    assign wrapped   = wrapped_q;
endmodule
